// File: rtl/alu_multicycle.sv
// alu_multicycle: clocked EX-stage ALU. It handles single-cycle arithmetic,
// logic and shift ops. MUL, DIV and MOD run iteratively, one bit per cycle.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   in_valid/in_ready   op handshake; accept when both are high on an edge
//   A, B, sel           operands and 4-bit opcode (shift amount = B[SHW-1:0])
//   out_valid           one-cycle pulse when Out/flags are updated
//   Out, N, Z, V, C     registered result and flags, held between pulses
//
// Optional build macro: ALU_DIV0_BYPASS_EN. When it is defined, DIV/MOD by zero
// is resolved at accept with single-cycle latency instead of iterating.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] Out,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             C
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010,
                         OP_DIV = 4'b0011, OP_MOD = 4'b0100, OP_AND = 4'b0101,
                         OP_OR  = 4'b0110, OP_XOR = 4'b0111, OP_SHL = 4'b1000,
                         OP_SHR = 4'b1001, OP_ASR = 4'b1010;

  typedef enum logic {IDLE, ITER} state_t;
  state_t state, stateNext;

  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] regHi, regLo, regOp;  // MUL: acc/multiplier/multiplicand; DIV: rem/quot/divisor
  logic [3:0]       regSel;
  logic             loadSingle, startIter, loadIter, isLong;

  // Single-cycle datapath
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   addSum, subSum, shlWide, shrWide, asrWide;
  logic [WIDTH-1:0] sRes;
  logic             sC, sV;

  assign amt     = B[SHW-1:0];
  assign addSum  = {1'b0, A} + {1'b0, B};
  assign subSum  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  // The extra bit on each shift catches the last bit shifted out. That bit is 0 for amt==0.
  assign shlWide = {1'b0, A} << amt;
  assign shrWide = {A, 1'b0} >> amt;
  assign asrWide = $signed({A, 1'b0}) >>> amt;

  always_comb begin
    sRes = A;
    sC   = 1'b0;
    sV   = 1'b0;
    case (sel)
      OP_ADD: begin
        sRes = addSum[WIDTH-1:0];
        sC   = addSum[WIDTH];
        sV   = (A[WIDTH-1] == B[WIDTH-1]) && (addSum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sRes = subSum[WIDTH-1:0];
        sC   = subSum[WIDTH];
        sV   = (A[WIDTH-1] != B[WIDTH-1]) && (subSum[WIDTH-1] != A[WIDTH-1]);
      end
      // DIV/MOD only take this path for a zero divisor (bypass build).
      OP_DIV: begin sRes = '1; sV = 1'b1; end
      OP_MOD: begin sRes = A;  sV = 1'b1; end
      OP_AND: sRes = A & B;
      OP_OR:  sRes = A | B;
      OP_XOR: sRes = A ^ B;
      OP_SHL: {sC, sRes} = shlWide;
      OP_SHR: {sRes, sC} = shrWide;
      OP_ASR: {sRes, sC} = asrWide;
      default: ;
    endcase
  end

`ifdef ALU_DIV0_BYPASS_EN
  assign isLong = (sel == OP_MUL) || (((sel == OP_DIV) || (sel == OP_MOD)) && (B != '0));
`else
  assign isLong = (sel == OP_MUL) || (sel == OP_DIV) || (sel == OP_MOD);
`endif

  // Iterative step: shift-add multiply (LSB first) or restoring divide (MSB first)
  logic [WIDTH:0]   mulSum, divShift;
  logic [WIDTH+1:0] divDiff;
  logic [WIDTH-1:0] hiNext, loNext, iRes;
  logic             iV;

  always_comb begin
    mulSum   = {1'b0, regHi} + (regLo[0] ? {1'b0, regOp} : '0);
    divShift = {regHi, regLo[WIDTH-1]};
    // The wide difference keeps a zero divisor from looking negative. The quotient then
    // fills with ones and the remainder collects A, which matches the div-by-zero result.
    divDiff  = {1'b0, divShift} - {2'b00, regOp};
    hiNext   = regHi;
    loNext   = regLo;
    iRes     = regLo;
    iV       = 1'b0;
    if (regSel == OP_MUL) begin
      hiNext = mulSum[WIDTH:1];
      loNext = {mulSum[0], regLo[WIDTH-1:1]};
      iRes   = loNext;
      iV     = |hiNext;
    end else begin
      hiNext = divDiff[WIDTH+1] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
      loNext = {regLo[WIDTH-2:0], ~divDiff[WIDTH+1]};
      iRes   = (regSel == OP_MOD) ? hiNext : loNext;
      iV     = (regOp == '0);
    end
  end

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    in_ready   = 1'b0;
    loadSingle = 1'b0;
    startIter  = 1'b0;
    loadIter   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (isLong) begin
            startIter = 1'b1;
            stateNext = ITER;
          end else begin
            loadSingle = 1'b1;
          end
        end
      end
      ITER: begin
        if (count == '0) begin
          loadIter  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      regHi     <= '0;
      regLo     <= '0;
      regOp     <= '0;
      regSel    <= '0;
      out_valid <= 1'b0;
      Out       <= '0;
      N         <= 1'b0;
      Z         <= 1'b0;
      V         <= 1'b0;
      C         <= 1'b0;
    end else begin
      out_valid <= loadSingle | loadIter;
      if (startIter) begin
        regHi  <= '0;
        regLo  <= (sel == OP_MUL) ? B : A;
        regOp  <= (sel == OP_MUL) ? A : B;
        regSel <= sel;
        count  <= SHW'(WIDTH - 1);
      end else if (state == ITER) begin
        regHi <= hiNext;
        regLo <= loNext;
        if (!loadIter) count <= count - 1'b1;
      end
      if (loadSingle) begin
        Out <= sRes;
        N   <= sRes[WIDTH-1];
        Z   <= (sRes == '0);
        C   <= sC;
        V   <= sV;
      end else if (loadIter) begin
        Out <= iRes;
        N   <= iRes[WIDTH-1];
        Z   <= (iRes == '0);
        C   <= 1'b0;
        V   <= iV;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;
  logic        clk = 1'b0;
  logic        rst;
  logic        inValid, inReady, outValid, n, z, v, c;
  logic [31:0] a, b, out;
  logic [3:0]  sel;
  logic        inValid8, inReady8, outValid8, n8, z8, v8, c8;
  logic [7:0]  a8, b8, out8;
  logic [3:0]  sel8;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .A(a), .B(b),
    .sel(sel), .out_valid(outValid), .Out(out), .N(n), .Z(z), .V(v), .C(c));

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8), .A(a8), .B(b8),
    .sel(sel8), .out_valid(outValid8), .Out(out8), .N(n8), .Z(z8), .V(v8), .C(c8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] res;
    logic        n, z, c, v;
  } exp_t;

  // Reference: plain arithmetic on 64-bit values
  function automatic exp_t refModel(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, s;
    logic [63:0] p;
    int          amt;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    amt = int'(y[4:0]);
    e.res = x; e.c = 1'b0; e.v = 1'b0;
    case (op)
      4'd0: begin
        p = 64'(x) + 64'(y); e.res = p[31:0]; e.c = p[32];
        s = sx + sy; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        e.res = x - y; e.c = (x >= y);
        s = sx - sy; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: begin p = 64'(x) * 64'(y); e.res = p[31:0]; e.v = (p[63:32] != 0); end
      4'd3: if (y == 0) begin e.res = 32'hFFFFFFFF; e.v = 1'b1; end else e.res = x / y;
      4'd4: if (y == 0) begin e.res = x; e.v = 1'b1; end else e.res = x % y;
      4'd5: e.res = x & y;
      4'd6: e.res = x | y;
      4'd7: e.res = x ^ y;
      4'd8: begin e.res = x << amt; e.c = (amt == 0) ? 1'b0 : x[32-amt]; end
      4'd9: begin e.res = x >> amt; e.c = (amt == 0) ? 1'b0 : x[amt-1]; end
      4'd10: begin e.res = 32'($signed(x) >>> amt); e.c = (amt == 0) ? 1'b0 : x[amt-1]; end
      default: ;
    endcase
    e.n = e.res[31];
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic runOp(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input string tag);
    exp_t e;
    int   expLat, lat;
    logic rdyLowOk;
    e = refModel(op, x, y);
    expLat = (op inside {4'd2, 4'd3, 4'd4}) ? 33 : 1;
`ifdef ALU_DIV0_BYPASS_EN
    if ((op inside {4'd3, 4'd4}) && (y == 0)) expLat = 1;
`endif
    @(negedge clk);
    check({tag, ".rdy"}, inReady, 1);
    sel = op; a = x; b = y; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0; a = $urandom; b = $urandom; sel = 4'($urandom);
    lat = 1; rdyLowOk = 1'b1;
    while (!outValid && lat < 100) begin
      if (inReady) rdyLowOk = 1'b0;
      inValid = (lat == 3);  // stray request while busy must be dropped
      @(negedge clk);
      lat++;
    end
    inValid = 1'b0;
    check({tag, ".lat"}, lat, expLat);
    if (expLat > 1) check({tag, ".busy"}, rdyLowOk, 1);
    check({tag, ".rdyOut"}, inReady, 1);
    check({tag, ".out"}, out, e.res);
    check({tag, ".nzcv"}, {n, z, c, v}, {e.n, e.z, e.c, e.v});
    @(negedge clk);
    check({tag, ".pulse"}, outValid, 0);
    check({tag, ".hold"}, out, e.res);
  endtask

  initial begin
    int   lat;
    logic quiet;
    logic [3:0]  op;
    logic [31:0] x, y;
    rst = 1'b1; inValid = 0; a = 0; b = 0; sel = 0;
    inValid8 = 0; a8 = 0; b8 = 0; sel8 = 0;
    repeat (2) @(negedge clk);
    check("rst.out", {out, n, z, c, v, outValid}, 0);
    check("rst.rdy", inReady, 1);
    rst = 1'b0;

    // Back-to-back single-cycle ops
    @(negedge clk);
    sel = 4'd0; a = 32'h7FFFFFFF; b = 32'd1; inValid = 1'b1;
    @(negedge clk);
    check("add.vld", outValid, 1);
    check("add.out", out, 32'h80000000);
    check("add.nzcv", {n, z, c, v}, 4'b1001);
    sel = 4'd1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    inValid = 1'b0;
    check("sub.vld", outValid, 1);
    check("sub.out", out, 0);
    check("sub.nzcv", {n, z, c, v}, 4'b0110);

    // Directed cases
    runOp(4'd2, 32'h00010000, 32'h00010000, "mul");
    runOp(4'd3, 32'd100, 32'd7, "div");
    runOp(4'd4, 32'd100, 32'd7, "mod");
    runOp(4'd3, 32'd9, 32'd0, "div0");
    runOp(4'd4, 32'd9, 32'd0, "mod0");
    runOp(4'd8, 32'h80000001, 32'd1, "shl");
    runOp(4'd10, 32'h80000000, 32'd31, "asr");
    runOp(4'd9, 32'hA5A5F00F, 32'd0, "shr0");
    runOp(4'd8, 32'h40000001, 32'h21, "shlwrap");
    runOp(4'd15, 32'h12345678, 32'h9, "other");

    // Random ops
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'($urandom_range(0, 40));
        1: y = 32'd0;
        default: y = $urandom;
      endcase
      runOp(op, x, y, $sformatf("rnd%0d", i));
    end

    // WIDTH=8 multiply latency
    @(negedge clk);
    sel8 = 4'd2; a8 = 8'd3; b8 = 8'd5; inValid8 = 1'b1;
    @(negedge clk);
    inValid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!outValid8 && lat < 50) begin @(negedge clk); lat++; end
    check("mul8.lat", lat, 9);
    check("mul8.out", out8, 8'd15);
    check("mul8.v", v8, 0);

    // Reset in the middle of a multiply on both widths
    runOp(4'd0, 32'd40, 32'd2, "pre");
    @(negedge clk);
    sel = 4'd2; a = $urandom; b = $urandom; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (k == 5) begin sel8 = 4'd2; a8 = 8'd17; b8 = 8'd19; end
      inValid8 = (k == 5);
      @(negedge clk);
    end
    inValid8 = 1'b0;
    check("abort.busy", inReady, 0);
    rst = 1'b1;
    #1;
    check("abort.out", {out, n, z, c, v, outValid}, 0);
    check("abort.out8", {out8, n8, z8, c8, v8, outValid8}, 0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (outValid || outValid8) quiet = 1'b0;
    end
    check("abort.noVld", quiet, 1);
    check("abort.rdy8", inReady8, 1);
    runOp(4'd0, 32'd2, 32'd3, "add23");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
